// File: rtl/matmul_pkg.sv
// Shared types and constants for the 10x10 matrix-multiply controller.
package matmul_pkg;

  localparam int unsigned MAT_N      = 10;
  localparam int unsigned ADDR_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WRITE,
    DONE
  } mm_state_t;

endpackage

// File: rtl/mac_unit.sv
// Unsigned multiply-accumulate register.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the accumulator (wins over en)
//   en       : add a*b into the accumulator
//   a, b     : DATA_WIDTH-bit unsigned operands
//   acc      : ACC_WIDTH-bit accumulator, wraps modulo 2^ACC_WIDTH
module mac_unit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

  logic [PROD_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]  acc_d;
  logic [ACC_WIDTH-1:0]  acc_q;

  // Next accumulator value; the product is zero-extended before the add.
  always_comb begin
    prod  = PROD_WIDTH'(a) * PROD_WIDTH'(b);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_WIDTH'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matmul_ctrl_10x10.sv
// Sequencer for C = A x B over three 10x10 storage blocks.
//   clk, rst                     : clock, synchronous active-high reset
//   start                        : begin a multiply (sampled in IDLE only)
//   busy, done                   : in-progress flag, one-cycle completion pulse
//   a_/b_en_ReadMat, *_row/colAddr : operand read port (data one cycle later)
//   a_readData, b_readData       : operand data
//   c_en_WriteMat, c_row/colAddr, c_writeData : result write port
module matmul_ctrl_10x10
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  a_en_ReadMat,
  output logic                  b_en_ReadMat,
  output logic [ADDR_WIDTH-1:0] a_rowAddr,
  output logic [ADDR_WIDTH-1:0] a_colAddr,
  output logic [ADDR_WIDTH-1:0] b_rowAddr,
  output logic [ADDR_WIDTH-1:0] b_colAddr,
  input  logic [DATA_WIDTH-1:0] a_readData,
  input  logic [DATA_WIDTH-1:0] b_readData,
  output logic                  c_en_WriteMat,
  output logic [ADDR_WIDTH-1:0] c_rowAddr,
  output logic [ADDR_WIDTH-1:0] c_colAddr,
  output logic [ACC_WIDTH-1:0]  c_writeData
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MAT_N - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  mm_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic                  valid_q, valid_d;
  logic                  acc_clr;
  logic [ACC_WIDTH-1:0]  acc;

  logic                  busy_q, busy_d, done_q, done_d;
  logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] a_row_q, a_row_d, a_col_q, a_col_d;
  logic [ADDR_WIDTH-1:0] b_row_q, b_row_d, b_col_q, b_col_d;
  logic [ADDR_WIDTH-1:0] c_row_q, c_row_d, c_col_q, c_col_d;

  mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (valid_q),
    .a   (a_readData),
    .b   (b_readData),
    .acc (acc)
  );

  // Next state, counters, and output values (outputs follow the next state
  // so they line up with the state they belong to once registered).
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_clr = 1'b1;
        end
      end
      FETCH: begin
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + ONE;
        end
      end
      DRAIN: state_d = WRITE;
      WRITE: begin
        acc_clr = 1'b1;
        k_d     = '0;
        state_d = FETCH;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + ONE;
          end
        end else begin
          j_d = j_q + ONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read data returns one cycle after a FETCH cycle.
    valid_d = (state_q == FETCH);

    busy_d  = (state_d == FETCH) || (state_d == DRAIN) || (state_d == WRITE);
    done_d  = (state_d == DONE);
    rd_en_d = (state_d == FETCH);
    wr_en_d = (state_d == WRITE);
    a_row_d = rd_en_d ? i_d : '0;
    a_col_d = rd_en_d ? k_d : '0;
    b_row_d = rd_en_d ? k_d : '0;
    b_col_d = rd_en_d ? j_d : '0;
    c_row_d = wr_en_d ? i_d : '0;
    c_col_d = wr_en_d ? j_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      a_row_q <= '0;
      a_col_q <= '0;
      b_row_q <= '0;
      b_col_q <= '0;
      c_row_q <= '0;
      c_col_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      a_row_q <= a_row_d;
      a_col_q <= a_col_d;
      b_row_q <= b_row_d;
      b_col_q <= b_col_d;
      c_row_q <= c_row_d;
      c_col_q <= c_col_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign a_en_ReadMat  = rd_en_q;
  assign b_en_ReadMat  = rd_en_q;
  assign a_rowAddr     = a_row_q;
  assign a_colAddr     = a_col_q;
  assign b_rowAddr     = b_row_q;
  assign b_colAddr     = b_col_q;
  assign c_en_WriteMat = wr_en_q;
  assign c_rowAddr     = c_row_q;
  assign c_colAddr     = c_col_q;
  // The accumulator holds the finished sum during the WRITE cycle.
  assign c_writeData   = wr_en_q ? acc : '0;

endmodule

// File: tb/tb_matmul_ctrl_10x10.sv
// Bench for matmul_ctrl_10x10 with behavioural 10x10 operand/result stores.
module tb_matmul_ctrl_10x10;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done;
  logic          a_en, b_en, c_en;
  logic [3:0]    a_row, a_col, b_row, b_col, c_row, c_col;
  logic [DW-1:0] a_rd = '0;
  logic [DW-1:0] b_rd = '0;
  logic [AW-1:0] c_wd;

  logic [DW-1:0] a_mem [10][10];
  logic [DW-1:0] b_mem [10][10];
  logic [AW-1:0] c_mem [10][10];

  int n_checks = 0;
  int n_fail   = 0;

  // per-run observations
  int cyc, done_cyc, n_wr, first_wr, seq_errs;
  logic busy1, done_busy, idle_busy, idle_done;
  int c_errs;

  always #5 clk = ~clk;

  matmul_ctrl_10x10 #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .a_en_ReadMat  (a_en),
    .b_en_ReadMat  (b_en),
    .a_rowAddr     (a_row),
    .a_colAddr     (a_col),
    .b_rowAddr     (b_row),
    .b_colAddr     (b_col),
    .a_readData    (a_rd),
    .b_readData    (b_rd),
    .c_en_WriteMat (c_en),
    .c_rowAddr     (c_row),
    .c_colAddr     (c_col),
    .c_writeData   (c_wd)
  );

  // Storage with one-cycle read latency.
  always @(posedge clk) begin
    if (a_en) a_rd <= a_mem[a_row][a_col];
    if (b_en) b_rd <= b_mem[b_row][b_col];
    if (c_en) c_mem[c_row][c_col] <= c_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One multiply from a start pulse; leaves the bench in the cycle after done.
  task automatic run_mult(input bit pulse);
    int r, e, ei, ej;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; done_cyc = 0; n_wr = 0; first_wr = 0; seq_errs = 0;
    busy1 = 1'b0; done_busy = 1'b1; idle_busy = 1'b1; idle_done = 1'b1;
    while (cyc <= 1210) begin
      if (cyc == 1) busy1 = busy;
      if (c_en) begin
        n_wr++;
        if (first_wr == 0) first_wr = cyc;
      end
      if (cyc <= 1200) begin
        r  = (cyc - 1) % 12;
        e  = (cyc - 1) / 12;
        ei = e / 10;
        ej = e % 10;
        if (!busy || done) seq_errs++;
        if (r < 10) begin
          if (!a_en || !b_en || c_en || 32'(a_row) != ei || 32'(a_col) != r ||
              32'(b_row) != r || 32'(b_col) != ej || c_wd != '0) seq_errs++;
        end else if (r == 10) begin
          if (a_en || b_en || c_en || a_row != 0 || b_col != 0) seq_errs++;
        end else begin
          if (a_en || b_en || !c_en || 32'(c_row) != ei || 32'(c_col) != ej) seq_errs++;
        end
      end
      if (done && done_cyc == 0) begin
        done_cyc  = cyc;
        done_busy = busy;
      end
      if (done_cyc != 0 && cyc == done_cyc + 1) begin
        idle_busy = busy;
        idle_done = done;
        break;
      end
      start = pulse && (cyc == 100 || cyc == 601);
      tick();
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic check_timing(input string tag);
    check({tag, "_busy_c1"}, 32'(busy1), 32'd1);
    check({tag, "_done_cyc"}, done_cyc, 1201);
    check({tag, "_done_busy"}, 32'(done_busy), 32'd0);
    check({tag, "_idle_busy_done"}, 32'({idle_busy, idle_done}), 32'd0);
    check({tag, "_first_wr"}, first_wr, 12);
    check({tag, "_n_wr"}, n_wr, 100);
    check({tag, "_seq_errs"}, seq_errs, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'({a_en, b_en}), 32'd0);
    check("rst_wr_en", 32'(c_en), 32'd0);
    check("rst_addrs", 32'({a_row, a_col, b_row, b_col, c_row, c_col}), 32'd0);
    check("rst_wdata", 32'(c_wd), 32'd0);
    rst = 1'b0;
    repeat (2) tick();
    check("idle_no_start_busy", 32'(busy), 32'd0);

    // Identity A, random B: C must equal B.
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++) begin
        a_mem[i][j] = (i == j) ? 8'd1 : 8'd0;
        b_mem[i][j] = 8'($urandom_range(0, 255));
      end
    run_mult(1'b0);
    check_timing("ident");
    c_errs = 0;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        if (c_mem[i][j] !== 20'(b_mem[i][j])) c_errs++;
    check("ident_c_errs", c_errs, 0);
    check("ident_c99", 32'(c_mem[9][9]), 32'(b_mem[9][9]));

    // All 0xFF operands, started immediately after the previous DONE.
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++) begin
        a_mem[i][j] = 8'hFF;
        b_mem[i][j] = 8'hFF;
      end
    run_mult(1'b0);
    check_timing("max");
    c_errs = 0;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        if (c_mem[i][j] !== 20'd650250) c_errs++;
    check("max_c_errs", c_errs, 0);
    check("max_c57", 32'(c_mem[5][7]), 32'd650250);

    // A[i][k]=i+k, B=1, with start pulses while busy.
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++) begin
        a_mem[i][j] = 8'(i + j);
        b_mem[i][j] = 8'd1;
      end
    repeat (3) tick();
    run_mult(1'b1);
    check_timing("pat");
    c_errs = 0;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        if (c_mem[i][j] !== 20'(10 * i + 45)) c_errs++;
    check("pat_c_errs", c_errs, 0);
    check("pat_c33", 32'(c_mem[3][3]), 32'd75);
    check("pat_c90", 32'(c_mem[9][0]), 32'd135);

    // Reset in cycle 500 of a multiply, then a clean restart.
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        b_mem[i][j] = 8'(j + 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_wr = 0;
    for (int c = 1; c <= 500; c++) begin
      if (c_en) n_wr++;
      if (c == 500) rst = 1'b1;
      tick();
    end
    check("rstmid_writes_before", n_wr, 41);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_en", 32'({a_en, b_en, c_en, done}), 32'd0);
    check("rstmid_addrs", 32'({a_row, a_col, b_row, b_col, c_row, c_col}), 32'd0);
    check("rstmid_wdata", 32'(c_wd), 32'd0);
    tick();
    rst = 1'b0;
    n_wr = 0;
    seq_errs = 0;
    for (int c = 0; c < 20; c++) begin
      if (c_en) n_wr++;
      if (done || busy || a_en) seq_errs++;
      tick();
    end
    check("rstmid_quiet_writes", n_wr, 0);
    check("rstmid_quiet_activity", seq_errs, 0);
    run_mult(1'b0);
    check_timing("restart");
    c_errs = 0;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        if (c_mem[i][j] !== 20'((j + 1) * (10 * i + 45))) c_errs++;
    check("restart_c_errs", c_errs, 0);
    check("restart_c94", 32'(c_mem[9][4]), 32'd675);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
